// File: rtl/trdb_packet_decoder.sv
// trdb_packet_decoder: reassembles one length-prefixed trace packet and decodes its fields
// Ports:
//   clk_i, rst_i                         clock, synchronous active-high reset
//   byte_valid_i, byte_i, byte_ready_o   byte stream: length byte, then payload bytes MSB-first
//   pkt_valid_o, pkt_ready_i             decoded-packet handshake; all outputs held while valid
//   format_o .. iaddr_o                  decoded fields; fields unused by the format are zero
//   has_addr_o                           packet carried (or reconstructed) an address
//   error_o                              packet malformed; qualified by pkt_valid_o
module trdb_packet_decoder #(
    parameter int XLEN      = 32,
    parameter int PRIV_LEN  = 2,
    parameter int CAUSE_LEN = 5,
    parameter int TVAL_LEN  = 32,
    parameter int MAX_BYTES = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 byte_valid_i,
    input  logic [7:0]           byte_i,
    output logic                 byte_ready_o,
    output logic                 pkt_valid_o,
    input  logic                 pkt_ready_i,
    output logic [1:0]           format_o,
    output logic [1:0]           subformat_o,
    output logic                 branch_o,
    output logic                 interrupt_o,
    output logic                 thaddr_o,
    output logic                 notify_o,
    output logic                 updiscon_o,
    output logic                 irreport_o,
    output logic                 ienable_o,
    output logic                 encoder_mode_o,
    output logic [1:0]           qual_status_o,
    output logic [2:0]           ioptions_o,
    output logic [PRIV_LEN-1:0]  priv_o,
    output logic [CAUSE_LEN-1:0] ecause_o,
    output logic [TVAL_LEN-1:0]  tval_o,
    output logic [4:0]           branches_o,
    output logic [30:0]          branch_map_o,
    output logic [XLEN-1:0]      iaddr_o,
    output logic                 has_addr_o,
    output logic                 error_o
);
    localparam int BW = MAX_BYTES * 8;
    localparam int T  = BW - 1;
    // bit offset of the interrupt flag within a F3/SF1 payload
    localparam int O_TR = 5 + PRIV_LEN + CAUSE_LEN;
    localparam logic [7:0] L_SF0 = 8'((5 + PRIV_LEN + XLEN + 7) / 8);
    localparam logic [7:0] L_SF1 = 8'((O_TR + 2 + XLEN + TVAL_LEN + 7) / 8);
    localparam logic [7:0] L_SF2 = 8'((4 + PRIV_LEN + 7) / 8);
    localparam logic [7:0] L_SF3 = 8'((11 + 7) / 8);
    localparam logic [7:0] L_F2  = 8'((5 + XLEN + 7) / 8);
    localparam logic [7:0] L_F1A = 8'((41 + XLEN + 7) / 8);
    localparam logic [7:0] L_F1N = 8'((38 + 7) / 8);

    typedef enum logic [1:0] {IDLE, PAYLOAD, DECODE, OUT} state_t;
    state_t state, state_nx;

    logic [7:0]           len, cnt, req;
    logic [BW-1:0]        pl;
    logic [XLEN-1:0]      latest;
    logic                 take, err;
    logic [1:0]           fmt, sf;
    logic                 d_branch, d_interrupt, d_thaddr, d_notify, d_updiscon, d_irreport;
    logic                 d_ienable, d_encoder_mode, d_has;
    logic [1:0]           d_qual_status;
    logic [2:0]           d_ioptions;
    logic [PRIV_LEN-1:0]  d_priv;
    logic [CAUSE_LEN-1:0] d_ecause;
    logic [TVAL_LEN-1:0]  d_tval;
    logic [4:0]           d_branches;
    logic [30:0]          d_map;
    logic [XLEN-1:0]      d_iaddr;

    assign take = byte_valid_i && byte_ready_o;
    assign fmt  = pl[T -: 2];
    assign sf   = pl[T-2 -: 2];

    always_ff @(posedge clk_i) begin
        state <= rst_i ? IDLE : state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (take) state_nx = (byte_i == 8'd0) ? DECODE : PAYLOAD;
            PAYLOAD: if (take && cnt == len - 8'd1) state_nx = DECODE;
            DECODE:  state_nx = OUT;
            OUT:     if (pkt_ready_i) state_nx = IDLE;
        endcase
    end

    always_comb begin
        byte_ready_o = (state == IDLE) || (state == PAYLOAD);
        pkt_valid_o  = (state == OUT);
    end

    // The buffer is cleared on every length byte so short packets read as zero-padded.
    // Bytes past MAX_BYTES match no slot and are dropped, but still advance the count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            len <= '0;
            cnt <= '0;
            pl  <= '0;
        end else if (take) begin
            if (state == IDLE) begin
                len <= byte_i;
                cnt <= '0;
                pl  <= '0;
            end else begin
                cnt <= cnt + 8'd1;
                for (int i = 0; i < MAX_BYTES; i++)
                    if (cnt == 8'(i)) pl[T-8*i -: 8] <= byte_i;
            end
        end
    end

    always_comb begin
        req            = 8'd0;
        d_branch       = 1'b0;
        d_interrupt    = 1'b0;
        d_thaddr       = 1'b0;
        d_notify       = 1'b0;
        d_updiscon     = 1'b0;
        d_irreport     = 1'b0;
        d_ienable      = 1'b0;
        d_encoder_mode = 1'b0;
        d_qual_status  = '0;
        d_ioptions     = '0;
        d_priv         = '0;
        d_ecause       = '0;
        d_tval         = '0;
        d_branches     = '0;
        d_map          = '0;
        d_iaddr        = '0;
        d_has          = 1'b0;
        case (fmt)
            2'd3: begin
                case (sf)
                    2'd0: begin
                        req      = L_SF0;
                        d_branch = pl[T-4];
                        d_priv   = pl[T-5 -: PRIV_LEN];
                        d_iaddr  = pl[T-5-PRIV_LEN -: XLEN];
                        d_has    = 1'b1;
                    end
                    2'd1: begin
                        req         = L_SF1;
                        d_branch    = pl[T-4];
                        d_priv      = pl[T-5 -: PRIV_LEN];
                        d_ecause    = pl[T-5-PRIV_LEN -: CAUSE_LEN];
                        d_interrupt = pl[T-O_TR];
                        d_thaddr    = pl[T-O_TR-1];
                        d_iaddr     = pl[T-O_TR-2 -: XLEN];
                        d_tval      = pl[T-O_TR-2-XLEN -: TVAL_LEN];
                        d_has       = 1'b1;
                    end
                    2'd2: begin
                        req    = L_SF2;
                        d_priv = pl[T-4 -: PRIV_LEN];
                    end
                    default: begin
                        req            = L_SF3;
                        d_ienable      = pl[T-4];
                        d_encoder_mode = pl[T-5];
                        d_qual_status  = pl[T-6 -: 2];
                        d_ioptions     = pl[T-8 -: 3];
                    end
                endcase
            end
            2'd2: begin
                req        = L_F2;
                d_iaddr    = pl[T-2 -: XLEN];
                d_notify   = pl[T-2-XLEN];
                d_updiscon = pl[T-3-XLEN];
                d_irreport = pl[T-4-XLEN];
                d_has      = 1'b1;
            end
            2'd1: begin
                d_branches = pl[T-2 -: 5];
                d_map      = pl[T-7 -: 31];
                if (d_branches == 5'd31) begin
                    // full branch map, no address: report the last known address
                    req     = L_F1N;
                    d_iaddr = latest;
                end else begin
                    req        = L_F1A;
                    d_iaddr    = latest + pl[T-38 -: XLEN];
                    d_notify   = pl[T-38-XLEN];
                    d_updiscon = pl[T-39-XLEN];
                    d_irreport = pl[T-40-XLEN];
                    d_has      = 1'b1;
                end
            end
            default: req = 8'd0;
        endcase
        err = (len == 8'd0) || (int'(len) > MAX_BYTES) || (fmt == 2'd0) || (len != req);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            format_o       <= '0;
            subformat_o    <= '0;
            branch_o       <= 1'b0;
            interrupt_o    <= 1'b0;
            thaddr_o       <= 1'b0;
            notify_o       <= 1'b0;
            updiscon_o     <= 1'b0;
            irreport_o     <= 1'b0;
            ienable_o      <= 1'b0;
            encoder_mode_o <= 1'b0;
            qual_status_o  <= '0;
            ioptions_o     <= '0;
            priv_o         <= '0;
            ecause_o       <= '0;
            tval_o         <= '0;
            branches_o     <= '0;
            branch_map_o   <= '0;
            iaddr_o        <= '0;
            has_addr_o     <= 1'b0;
            error_o        <= 1'b0;
            latest         <= '0;
        end else if (state == DECODE) begin
            format_o       <= fmt;
            subformat_o    <= (fmt == 2'd3 || err) ? sf : 2'd0;
            branch_o       <= d_branch;
            interrupt_o    <= d_interrupt;
            thaddr_o       <= d_thaddr;
            notify_o       <= d_notify;
            updiscon_o     <= d_updiscon;
            irreport_o     <= d_irreport;
            ienable_o      <= d_ienable;
            encoder_mode_o <= d_encoder_mode;
            qual_status_o  <= d_qual_status;
            ioptions_o     <= d_ioptions;
            priv_o         <= d_priv;
            ecause_o       <= d_ecause;
            tval_o         <= d_tval;
            branches_o     <= d_branches;
            branch_map_o   <= d_map;
            iaddr_o        <= d_iaddr;
            has_addr_o     <= d_has && !err;
            error_o        <= err;
            if (d_has && !err) latest <= d_iaddr;
        end
    end
endmodule
